// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vram_pkg
//  Description : Shared types and constants for the VRAM arbiter: the
//                arbiter state encoding and the slot budget of one
//                character period.
//  Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

    // Arbiter sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        VCHAR     = 3'd1,
        VATTR     = 3'd2,
        VLAST     = 3'd3,
        CPU_ISSUE = 3'd4,
        CPU_DATA  = 3'd5
    } vram_state_e;

    // Slots consumed by one video fetch (char address, attr address, last
    // data capture) and by one CPU access (issue, data).
    localparam int VID_SLOTS          = 3;
    localparam int CPU_SLOTS          = 2;

    // Closest divclk spacing that never drops a fetch when a CPU access
    // is squeezed in between two fetches (idle slot + video + CPU).
    localparam int MIN_DIVCLK_SPACING = 6;

endpackage : vram_pkg
`default_nettype wire

// File: rtl/vram_cpu_handshake.sv
`default_nettype none
// ============================================================================
//  Module      : vram_cpu_handshake
//  Description : ISA-side handshake for VRAM accesses. Tracks whether the
//                current request has already been served, produces the
//                pending request towards the arbiter, drives IOCHRDY and
//                latches read data.
//  Ports       : clk, reset        - clock, async active-high reset
//                cpu_req           - level request from ISA decode
//                cpu_write         - 1 = write access
//                display_enable    - CRTC active-display flag
//                access_done       - arbiter is in its CPU data slot
//                ram_rdata         - VRAM read data (1-cycle latency)
//                pending           - request eligible for a grant
//                cpu_ready         - IOCHRDY, low = wait
//                cpu_rdata         - last completed read data
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_cpu_handshake #(
    parameter bit BLANK_ONLY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_write,
    input  logic       display_enable,
    input  logic       access_done,
    input  logic [7:0] ram_rdata,
    output logic       pending,
    output logic       cpu_ready,
    output logic [7:0] cpu_rdata
);

    logic       r_served;
    logic [7:0] r_cpu_rdata;
    logic       w_window_open;

    // In snow-free mode the CPU only gets the RAM outside active display.
    assign w_window_open = (BLANK_ONLY == 1'b0) || !display_enable;

    assign pending   = cpu_req && !r_served && w_window_open;

    // Combinational so IOCHRDY drops in the very cycle the request appears.
    assign cpu_ready = !(cpu_req && !r_served);
    assign cpu_rdata = r_cpu_rdata;

    // served stays set while the request is held so a long ISA cycle is
    // not serviced twice; it clears the cycle after the request drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_served    <= 1'b0;
            r_cpu_rdata <= 8'h00;
        end else begin
            if (access_done) begin
                r_served <= 1'b1;
            end else if (!cpu_req) begin
                r_served <= 1'b0;
            end

            if (access_done && !cpu_write) begin
                r_cpu_rdata <= ram_rdata;
            end
        end
    end

endmodule : vram_cpu_handshake
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_arbiter
//  Description : Shares the single-port video RAM between the CRTC
//                character/attribute fetch (one per divclk) and ISA CPU
//                accesses (at most one per character period). The CPU is
//                stretched through cpu_ready until its access completes.
//  Ports       : clk, reset        - clock, async active-high reset
//                divclk            - character clock enable, 1 clk wide
//                display_enable    - CRTC active-display flag
//                mem_addr          - CRTC word address
//                cpu_req/cpu_write/cpu_addr/cpu_wdata - ISA access
//                cpu_rdata, cpu_ready                 - ISA response
//                ram_addr/ram_we/ram_wdata/ram_rdata  - VRAM port
//                char_byte, attr_byte, fetch_valid    - fetch result
//                overrun           - sticky, a divclk was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter
    import vram_pkg::*;
#(
    parameter bit BLANK_ONLY = 1'b1,
    parameter int AW         = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          divclk,
    input  logic          display_enable,
    input  logic [13:0]   mem_addr,
    input  logic          cpu_req,
    input  logic          cpu_write,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ready,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    output logic [7:0]    char_byte,
    output logic [7:0]    attr_byte,
    output logic          fetch_valid,
    output logic          overrun
);

    vram_state_e   r_state;
    vram_state_e   w_state_next;

    logic [AW-1:0] r_vaddr;
    logic          r_vid_defer;
    logic [7:0]    r_char_byte;
    logic [7:0]    r_attr_byte;
    logic          r_fetch_valid;
    logic          r_overrun;

    logic [AW-1:0] w_vaddr_load;
    logic          w_vaddr_latch;
    logic          w_defer_set;
    logic          w_defer_clr;
    logic          w_overrun_set;
    logic          w_pending;
    logic          w_access_done;
    logic          w_unused_mem_msb;

    // Word address to byte address; the top CRTC address bit has no
    // meaning for a 16 KB RAM.
    assign w_vaddr_load     = AW'({mem_addr[12:0], 1'b0});
    assign w_unused_mem_msb = mem_addr[13];

    assign w_access_done = (r_state == CPU_DATA);

    vram_cpu_handshake #(
        .BLANK_ONLY (BLANK_ONLY)
    ) u_handshake (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_write      (cpu_write),
        .display_enable (display_enable),
        .access_done    (w_access_done),
        .ram_rdata      (ram_rdata),
        .pending        (w_pending),
        .cpu_ready      (cpu_ready),
        .cpu_rdata      (cpu_rdata)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_vaddr_latch = 1'b0;
        w_defer_set   = 1'b0;
        w_defer_clr   = 1'b0;
        w_overrun_set = 1'b0;

        case (r_state)
            IDLE: begin
                // Video wins a tie so the display never loses a fetch to
                // the CPU.
                if (divclk) begin
                    w_vaddr_latch = 1'b1;
                    w_state_next  = VCHAR;
                end else if (w_pending) begin
                    w_state_next  = CPU_ISSUE;
                end
            end
            VCHAR: begin
                w_overrun_set = divclk;
                w_state_next  = VATTR;
            end
            VATTR: begin
                w_overrun_set = divclk;
                w_state_next  = VLAST;
            end
            VLAST: begin
                w_overrun_set = divclk;
                w_state_next  = IDLE;
            end
            CPU_ISSUE: begin
                // A CPU access already on the RAM cannot be pre-empted;
                // remember the fetch and run it right after.
                if (divclk) begin
                    w_vaddr_latch = 1'b1;
                    w_defer_set   = 1'b1;
                end
                w_state_next = CPU_DATA;
            end
            CPU_DATA: begin
                w_defer_clr = 1'b1;
                if (divclk) begin
                    w_vaddr_latch = 1'b1;
                end
                if (r_vid_defer || divclk) begin
                    w_state_next = VCHAR;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RAM drive, decoded purely from state so reset kills ram_we at once
    // ------------------------------------------------------------------
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 8'h00;

        case (r_state)
            VCHAR: begin
                ram_addr = r_vaddr;
            end
            VATTR: begin
                ram_addr = r_vaddr + AW'(1);
            end
            CPU_ISSUE: begin
                ram_addr  = cpu_addr;
                ram_we    = cpu_write;
                ram_wdata = cpu_wdata;
            end
            default: begin
                ram_addr = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Video datapath and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vaddr       <= '0;
            r_vid_defer   <= 1'b0;
            r_char_byte   <= 8'h00;
            r_attr_byte   <= 8'h00;
            r_fetch_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_vaddr_latch) begin
                r_vaddr <= w_vaddr_load;
            end

            if (w_defer_set) begin
                r_vid_defer <= 1'b1;
            end else if (w_defer_clr) begin
                r_vid_defer <= 1'b0;
            end

            // RAM data lags the address by one cycle: the char byte is on
            // ram_rdata during VATTR, the attr byte during VLAST.
            if (r_state == VATTR) begin
                r_char_byte <= ram_rdata;
            end
            if (r_state == VLAST) begin
                r_attr_byte <= ram_rdata;
            end

            r_fetch_valid <= (r_state == VLAST);

            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign char_byte   = r_char_byte;
    assign attr_byte   = r_attr_byte;
    assign fetch_valid = r_fetch_valid;
    assign overrun     = r_overrun;

endmodule : vram_arbiter
`default_nettype wire
